std_seq_mem_d1: RTL and testbench
=================================

# std_seq_mem_d1

Sequential one-dimensional memory primitive with registered, pipelined reads and explicit read/write enables. Rows are `WIDTH` bits and the depth is `SIZE`. Read latency is parameterised by `READ_LATENCY`. The block adds out-of-bounds error reporting and simultaneous-access error reporting. It sits alongside the combinational-read memory primitives and is the target the compiler lowers to when designs need FPGA block-RAM-compatible timing.

## Interface
Parameters:
- `WIDTH`, 32, data bits per row.
- `SIZE`, 16, number of rows; must be ≥ 1.
- `IDX_SIZE`, 4, address width; must be ≥ clog2(`SIZE`) and ≥ 1.
- `READ_LATENCY`, 1, cycles from `read_en` to data; legal range 1..4.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr0`  in  `IDX_SIZE`  row address for the current request.
- `write_data`  in  `WIDTH`  data to store.
- `write_en`  in  1  write request this cycle.
- `read_en`  in  1  read request this cycle.
- `read_data`  out  `WIDTH`  registered read result; holds until the next read completes.
- `done`  out  1  one-cycle completion pulse for a read or a write.
- `error`  out  1  sticky error flag; cleared only by `reset`.

## Operation
- Reset (`reset`=1 at an edge):
  - `read_data`←0, `done`←0, `error`←0.
  - All in-flight read pipeline stages are invalidated.
  - Memory contents are not cleared.
  - Requests presented while `reset`=1 are ignored.
- Write (`write_en`=1, `read_en`=0, `addr0`<`SIZE`):
  - `mem[addr0]`←`write_data` at edge N.
  - `done`=1 during cycle N+1.
- Read (`read_en`=1, `write_en`=0, `addr0`<`SIZE`):
  - `mem[addr0]` is sampled into pipeline stage 0 at edge N.
  - The value moves one stage per edge.
  - At edge N+`READ_LATENCY`−1 it is loaded into `read_data`, so it is visible during cycle N+`READ_LATENCY`.
  - `done`=1 during that same cycle.
- Read value is the row contents at the issue edge. A later write to the same row does not alter an in-flight read.
- Throughput is one request per cycle. Back-to-back reads produce back-to-back `done` pulses in issue order.
- `done` is the OR of write completion and read completion. If both fall in the same cycle, `done` is a single-cycle 1; no counting is implied.
- Simultaneous `read_en`=1 and `write_en`=1:
  - The write is performed and the read is dropped (no pipeline entry, no read `done`).
  - `error`←1 at the same edge.
- Out of bounds (`addr0` ≥ `SIZE`) with `write_en` or `read_en`:
  - Memory is unchanged.
  - A read still completes on schedule with `read_data`=0 and `done`=1.
  - A write still produces `done`=1 at N+1.
  - `error`←1.
- Reset mid-operation: pending reads are discarded and no `done` appears for them after reset deasserts.
- `read_data` does not change except when a read completes or on reset.

## Timing
- Write latency is 1 cycle (request at N, `done` in N+1).
- Read latency is exactly `READ_LATENCY` cycles, independent of traffic.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset has priority over all requests at the same edge.
- Write-then-read of the same row in consecutive cycles (write at N, read at N+1) returns the new data.

## Structure
- Package `std_mem_pkg`:
  - `READ_LATENCY` legal bounds (`MIN_READ_LATENCY`=1, `MAX_READ_LATENCY`=4).
  - Elaboration-time check that `READ_LATENCY` is in range and `IDX_SIZE` ≥ clog2(`SIZE`); violation is a fatal error.
- Sub-module `std_valid_delay`:
  - Parameters `WIDTH` and `DEPTH`.
  - A valid+data shift register with synchronous clear.
  - Used for read stages 1..`READ_LATENCY`−1; degenerates to a wire when `DEPTH`=0.
- Top level holds:
  - the memory array;
  - the stage-0 capture;
  - the write-done flop;
  - the error flop;
  - the output register.

## Test plan
- Reset: hold `reset` 2 cycles, then check `read_data`=0, `done`=0, `error`=0; write 0xDEADBEEF to row 3, pulse `reset`, read row 3 → 0xDEADBEEF (contents survive reset).
- Write/read, `READ_LATENCY`=2: write 0x11 to row 5 at N → `done` in N+1; `read_en` row 5 at N+2 → `read_data`=0x11 and `done` in N+4 only.
- Pipelined reads, `READ_LATENCY`=3: rows 0..3 preloaded with 0xA0..0xA3, `read_en` on 4 consecutive cycles → 4 consecutive `done` pulses with 0xA0, 0xA1, 0xA2, 0xA3; write 0xFF to row 1 one cycle after issuing its read → that read still returns 0xA1.
- Simultaneous access: `read_en`=`write_en`=1, row 2, data 0x77 → row 2 becomes 0x77, one `done` (write) in N+1, no read `done`, `error`=1 and it stays 1.
- Out of bounds, `SIZE`=10, `IDX_SIZE`=4: write 0x5 to addr 12 → no row changes, `done` in N+1, `error`=1; read addr 15 → `read_data`=0 with `done` at N+`READ_LATENCY`.
- Reset mid-read, `READ_LATENCY`=4: issue read at N, assert `reset` at N+2 → no `done` at N+4, `read_data`=0.

Source files
------------

// File: rtl/std_mem_pkg.sv
// Shared limits and elaboration-time parameter checks for the sequential memory primitives.
package std_mem_pkg;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    function automatic bit latency_ok(input int lat);
        return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
    endfunction

    function automatic bit geometry_ok(input int size, input int idx_size);
        return (size >= 1) && (idx_size >= 1) && (idx_size >= $clog2(size));
    endfunction

endpackage

// File: rtl/std_valid_delay.sv
// Valid+data shift register with synchronous clear; collapses to a wire when DEPTH is 0.
module std_valid_delay #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            logic [DEPTH-1:0]            valid_q;
            logic [DEPTH-1:0]            valid_d;
            logic [DEPTH-1:0][WIDTH-1:0] data_q;
            logic [DEPTH-1:0][WIDTH-1:0] data_d;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    assign valid_d[gi] = in_valid;
                    assign data_d[gi]  = in_data;
                end else begin : g_body
                    assign valid_d[gi] = valid_q[gi-1];
                    assign data_d[gi]  = data_q[gi-1];
                end
            end

            // Only the valid bits need clearing; stale data is never qualified.
            always_ff @(posedge clk) begin
                if (clr) begin
                    valid_q <= '0;
                end else begin
                    valid_q <= valid_d;
                end
                data_q <= data_d;
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/std_seq_mem_d1.sv
// One-dimensional memory with pipelined registered reads, write/read done pulses
// and a sticky error flag for out-of-range or simultaneous read+write requests.
module std_seq_mem_d1
    import std_mem_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int SIZE         = 16,
    parameter int IDX_SIZE     = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_SIZE-1:0] addr0,
    input  logic [WIDTH-1:0]    write_data,
    input  logic                write_en,
    input  logic                read_en,
    output logic [WIDTH-1:0]    read_data,
    output logic                done,
    output logic                error
);

    generate
        if (!latency_ok(READ_LATENCY) || !geometry_ok(SIZE, IDX_SIZE)) begin : g_bad_params
            $fatal(1, "std_seq_mem_d1: illegal READ_LATENCY/SIZE/IDX_SIZE combination");
        end
    endgenerate

    localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [WIDTH-1:0] mem [SIZE];
    logic [ROW_W-1:0] row;
    logic             in_bounds;
    logic             wr_ok;

    logic             s0_valid;
    logic [WIDTH-1:0] s0_data;
    logic             dly_valid;
    logic [WIDTH-1:0] dly_data;

    logic [WIDTH-1:0] read_data_q, read_data_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    assign row       = addr0[ROW_W-1:0];
    assign in_bounds = (32'(addr0) < SIZE);
    assign wr_ok     = write_en && in_bounds && !reset;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[row] <= write_data;
        end
    end

    // A read that collides with a write is dropped; out-of-range reads still
    // travel the pipeline so they complete on schedule with zero data.
    always_comb begin
        s0_valid = read_en && !write_en;
        s0_data  = in_bounds ? mem[row] : '0;
    end

    std_valid_delay #(
        .WIDTH (WIDTH),
        .DEPTH (READ_LATENCY - 1)
    ) u_read_pipe (
        .clk       (clk),
        .clr       (reset),
        .in_valid  (s0_valid),
        .in_data   (s0_data),
        .out_valid (dly_valid),
        .out_data  (dly_data)
    );

    always_comb begin
        read_data_d = dly_valid ? dly_data : read_data_q;
        done_d      = write_en || dly_valid;
        error_d     = error_q
                    || (write_en && read_en)
                    || ((write_en || read_en) && !in_bounds);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign read_data = read_data_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// Randomized and directed checks of std_seq_mem_d1 against a queue-based reference model.
module tb_std_seq_mem_d1;

    localparam int W    = 32;
    localparam int SIZE = 10;
    localparam int IDX  = 4;
    localparam int L    = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           write_en = 1'b0;
    logic           read_en = 1'b0;
    logic [IDX-1:0] addr0 = '0;
    logic [W-1:0]   write_data = '0;
    logic [W-1:0]   read_data;
    logic           done;
    logic           error;

    always #5 clk = ~clk;

    std_seq_mem_d1 #(
        .WIDTH        (W),
        .SIZE         (SIZE),
        .IDX_SIZE     (IDX),
        .READ_LATENCY (L)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr0      (addr0),
        .write_data (write_data),
        .write_en   (write_en),
        .read_en    (read_en),
        .read_data  (read_data),
        .done       (done),
        .error      (error)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } pend_t;

    logic [W-1:0] mdl_mem [SIZE];
    logic [W-1:0] mdl_rd   = '0;
    logic         mdl_done = 1'b0;
    logic         mdl_err  = 1'b0;
    pend_t        pend [$];

    // Drive one cycle, advance the model by one edge, then settle past the edge.
    task automatic step(input logic rst, input logic we, input logic re,
                        input int addr, input logic [W-1:0] wd);
        pend_t p;
        bit    inb;
        bit    fin;
        reset      = rst;
        write_en   = we;
        read_en    = re;
        addr0      = IDX'(addr);
        write_data = wd;
        @(posedge clk);
        cyc++;
        inb = (addr < SIZE);
        fin = 1'b0;
        if (rst) begin
            pend.delete();
            mdl_rd   = '0;
            mdl_done = 1'b0;
            mdl_err  = 1'b0;
        end else begin
            if (re && !we) begin
                p.due  = cyc + L - 1;
                p.data = inb ? mdl_mem[addr] : '0;
                pend.push_back(p);
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                mdl_rd = pend[0].data;
                fin    = 1'b1;
                void'(pend.pop_front());
            end
            if (we) begin
                fin = 1'b1;
                if (inb) mdl_mem[addr] = wd;
            end
            if ((we && re) || ((we || re) && !inb)) mdl_err = 1'b1;
            mdl_done = fin;
        end
        #1;
        $display("txn %0d rst=%0b we=%0b re=%0b addr=%0d wd=%h -> done=%0b rd=%h err=%0b",
                 cyc, rst, we, re, addr, wd, done, read_data, error);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 0, '0);
        step(1'b1, 1'b0, 1'b0, 0, '0);
        checks++;
        if (read_data !== '0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rd=%h done=%b err=%b, need 0/0/0", read_data, done, error);
        end
        for (int i = 0; i < SIZE; i++) step(1'b0, 1'b1, 1'b0, i, 32'h1000 + W'(i));
        step(1'b0, 1'b1, 1'b0, 3, 32'hDEADBEEF);
        step(1'b1, 1'b0, 1'b0, 0, '0);
        step(1'b0, 1'b0, 1'b1, 3, '0);
        repeat (L - 1) idle();
        checks++;
        if (done !== 1'b1 || read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_keeps_mem: done=%b rd=%h, need 1/deadbeef", done, read_data);
        end
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b1, 1'b0, 5, 32'h11);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL write_done: done=%b, need 1", done);
        end
        idle();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL write_done_single: done=%b, need 0", done);
        end
        step(1'b0, 1'b0, 1'b1, 5, '0);
        for (int k = 0; k <= L; k++) begin
            if (k > 0) idle();
            checks++;
            if (done !== (k == L - 1)) begin
                errors++;
                $display("FAIL read_latency k=%0d: done=%b, need %0b", k, done, (k == L - 1));
            end
            if (k == L - 1) begin
                checks++;
                if (read_data !== 32'h11) begin
                    errors++;
                    $display("FAIL read_data: rd=%h, need 00000011", read_data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, i, 32'hA0 + W'(i));
        for (int t = 0; t < L + 4; t++) begin
            if (t < 4) step(1'b0, 1'b0, 1'b1, t, '0);
            else idle();
            idx = t - (L - 1);
            checks++;
            if (done !== (idx >= 0 && idx < 4)) begin
                errors++;
                $display("FAIL b2b_done t=%0d: done=%b, need %0b", t, done, (idx >= 0 && idx < 4));
            end
            if (idx >= 0 && idx < 4) begin
                checks++;
                if (read_data !== 32'hA0 + W'(idx)) begin
                    errors++;
                    $display("FAIL b2b_data t=%0d: rd=%h, need %h", t, read_data, 32'hA0 + W'(idx));
                end
            end
        end
        step(1'b0, 1'b0, 1'b1, 1, '0);
        step(1'b0, 1'b1, 1'b0, 1, 32'hFF);
        repeat (L - 2) idle();
        checks++;
        if (done !== 1'b1 || read_data !== 32'hA1) begin
            errors++;
            $display("FAIL inflight_isolation: done=%b rd=%h, need 1/000000a1", done, read_data);
        end
        step(1'b0, 1'b0, 1'b1, 1, '0);
        repeat (L - 1) idle();
        checks++;
        if (read_data !== 32'hFF) begin
            errors++;
            $display("FAIL write_then_read: rd=%h, need 000000ff", read_data);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b0, 1'b0, 0, '0);
        step(1'b0, 1'b1, 1'b1, 2, 32'h77);
        checks++;
        if (done !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL simul_first: done=%b err=%b, need 1/1", done, error);
        end
        for (int k = 0; k < L + 1; k++) begin
            idle();
            checks++;
            if (done !== 1'b0 || error !== 1'b1) begin
                errors++;
                $display("FAIL simul_after k=%0d: done=%b err=%b, need 0/1", k, done, error);
            end
        end
        step(1'b0, 1'b0, 1'b1, 2, '0);
        repeat (L - 1) idle();
        checks++;
        if (done !== 1'b1 || read_data !== 32'h77) begin
            errors++;
            $display("FAIL simul_wrote: done=%b rd=%h, need 1/00000077", done, read_data);
        end
    endtask

    task automatic test_out_of_bounds();
        step(1'b1, 1'b0, 1'b0, 0, '0);
        step(1'b0, 1'b1, 1'b0, 12, 32'h5);
        checks++;
        if (done !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL oob_write: done=%b err=%b, need 1/1", done, error);
        end
        step(1'b0, 1'b0, 1'b1, 2, '0);
        repeat (L - 1) idle();
        step(1'b0, 1'b0, 1'b1, 15, '0);
        for (int k = 0; k < L; k++) begin
            if (k > 0) idle();
            checks++;
            if (done !== (k == L - 1) || (k == L - 1 && read_data !== '0)) begin
                errors++;
                $display("FAIL oob_read k=%0d: done=%b rd=%h, need %0b/0", k, done, read_data, (k == L - 1));
            end
        end
        for (int t = 0; t < SIZE + L; t++) begin
            if (t < SIZE) step(1'b0, 1'b0, 1'b1, t, '0);
            else idle();
            checks++;
            if (done !== mdl_done || read_data !== mdl_rd) begin
                errors++;
                $display("FAIL oob_rows_intact t=%0d: done=%b rd=%h, need %b/%h", t, done, read_data, mdl_done, mdl_rd);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        step(1'b0, 1'b0, 1'b1, 5, '0);
        repeat (L - 2) idle();
        step(1'b1, 1'b0, 1'b0, 0, '0);
        for (int k = 0; k < L + 1; k++) begin
            idle();
            checks++;
            if (done !== 1'b0 || read_data !== '0) begin
                errors++;
                $display("FAIL reset_mid_read k=%0d: done=%b rd=%h, need 0/0", k, done, read_data);
            end
        end
    endtask

    task automatic test_random();
        int op;
        int addr;
        for (int n = 0; n < 400; n++) begin
            op   = $urandom_range(0, 19);
            addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, SIZE - 1);
            if (op < 8)       step(1'b0, 1'b0, 1'b1, addr, '0);
            else if (op < 14) step(1'b0, 1'b1, 1'b0, addr, W'($urandom()));
            else if (op < 15) step(1'b0, 1'b1, 1'b1, addr, W'($urandom()));
            else if (op < 19) idle();
            else              step(1'b1, 1'b0, 1'b1, addr, '0);
            checks++;
            if (done !== mdl_done || read_data !== mdl_rd || error !== mdl_err) begin
                errors++;
                $display("FAIL random n=%0d: done=%b rd=%h err=%b, need %b/%h/%b",
                         n, done, read_data, error, mdl_done, mdl_rd, mdl_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_simultaneous();
        test_out_of_bounds();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
